// File: rtl/stream_packetizer_pkg.sv
// Shared types and helpers for the stream packetizer.
// Holds the FSM encoding and the counter width rule.
package stream_packetizer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        EMIT
    } state_e;

    // A zero count still needs a one-bit register.
    function automatic int cnt_w(input int n);
        return ($clog2(n + 1) > 0) ? $clog2(n + 1) : 1;
    endfunction

    function automatic int eot_bit(input int din);
        return din;
    endfunction

endpackage

// File: rtl/stream_packetizer_timer.sv
// Idle-cycle counter that closes a partial packet.
// Expiry is flagged on the last idle cycle before the limit.
module stream_packetizer_timer
    import stream_packetizer_pkg::*;
#(
    parameter int TIMEOUT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic tick_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int TW = cnt_w(TIMEOUT);

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    always_comb begin
        timer_d = timer_q;
        if (clear_i) begin
            timer_d = '0;
        end else if (tick_i && enable_i) begin
            timer_d = timer_q + 1'b1;
        end
    end

    assign expired_o = enable_i && (timer_q == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule

// File: rtl/stream_packetizer.sv
// Regroups a valid/ready word stream into eot-framed packets.
// One look-ahead word is held until its eot bit is known.
module stream_packetizer
    import stream_packetizer_pkg::*;
#(
    parameter int DIN     = 16,
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           din_valid,
    output logic           din_ready,
    input  logic [DIN-1:0] din_data,
    output logic           dout_valid,
    input  logic           dout_ready,
    output logic [DIN:0]   dout_data
);

    localparam int LW  = cnt_w(MAX_LEN);
    localparam int EOT = eot_bit(DIN);

    state_e          state_q, state_d;
    logic [DIN-1:0]  hold_q, hold_d;
    logic [LW-1:0]   len_q, len_d;
    logic            eot;
    logic            t_clear;
    logic            t_tick;
    logic            t_expired;

    stream_packetizer_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (t_clear),
        .tick_i   (t_tick),
        .enable_i (TIMEOUT != 0),
        .expired_o(t_expired)
    );

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        len_d      = len_q;
        din_ready  = 1'b1;
        dout_valid = 1'b0;
        eot        = 1'b0;
        t_clear    = 1'b0;
        t_tick     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (din_valid) begin
                    hold_d  = din_data;
                    len_d   = LW'(1);
                    t_clear = 1'b1;
                    state_d = (MAX_LEN == 1) ? EMIT : HOLD;
                end
            end
            HOLD: begin
                din_ready  = dout_ready;
                dout_valid = din_valid;
                if (din_valid && dout_ready) begin
                    hold_d  = din_data;
                    len_d   = len_q + 1'b1;
                    t_clear = 1'b1;
                    if (len_q == LW'(MAX_LEN - 1)) begin
                        state_d = EMIT;
                    end
                end else if (!din_valid) begin
                    // A word offered on the expiry cycle wins over the timeout.
                    t_tick = 1'b1;
                    if (t_expired) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                din_ready  = dout_ready;
                dout_valid = 1'b1;
                eot        = 1'b1;
                if (dout_ready) begin
                    if (din_valid) begin
                        hold_d  = din_data;
                        len_d   = LW'(1);
                        t_clear = 1'b1;
                        state_d = (MAX_LEN == 1) ? EMIT : HOLD;
                    end else begin
                        len_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        dout_data          = {1'b0, hold_q};
        dout_data[EOT]     = eot;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_stream_packetizer.sv
// Scoreboard bench for stream_packetizer, two parameter sets.
// A packet-level model predicts ready/valid and framed words.
module tb_stream_packetizer;

    localparam int ML [2] = '{4, 1};
    localparam int TO     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic [15:0] din_data = '0;
    logic        dout_ready = 1'b0;

    logic [1:0]  dut_rdy;
    logic [1:0]  dut_vld;
    logic [16:0] dut_dat [2];

    int errors = 0;
    int checks = 0;

    logic [16:0] q0[$];
    logic [16:0] q1[$];

    bit          pv [2];
    bit          pc [2];
    logic [15:0] pd [2];
    int          cnt [2];
    int          idle [2];
    bit          er [2];
    bit          ev [2];

    stream_packetizer #(.DIN(16), .MAX_LEN(4), .TIMEOUT(TO)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_ready (dut_rdy[0]),
        .din_data  (din_data),
        .dout_valid(dut_vld[0]),
        .dout_ready(dout_ready),
        .dout_data (dut_dat[0])
    );

    stream_packetizer #(.DIN(16), .MAX_LEN(1), .TIMEOUT(TO)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .din_valid (din_valid),
        .din_ready (dut_rdy[1]),
        .din_data  (din_data),
        .dout_valid(dut_vld[1]),
        .dout_ready(dout_ready),
        .dout_data (dut_dat[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k,
                       input logic [16:0] act, input logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got=%h want=%h",
                     nm, k, $time, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [16:0] v);
        if (k == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    // Packet-level reference: one pending word whose eot is settled
    // either by a packet-length limit or by TO idle cycles.
    task automatic model_step(input int k);
        if (rst) begin
            pv[k] = 0; pc[k] = 0; cnt[k] = 0; idle[k] = 0;
            er[k] = 1; ev[k] = 0;
            return;
        end
        er[k] = !pv[k] || dout_ready;
        ev[k] = pv[k] && (pc[k] || din_valid);
        if (pv[k]) begin
            if (ev[k] && dout_ready) begin
                push(k, {pc[k], pd[k]});
                if (pc[k]) begin
                    cnt[k] = 0;
                    pv[k] = 0;
                end
            end else if (!din_valid && !pc[k]) begin
                idle[k]++;
                if (idle[k] == TO) pc[k] = 1;
            end
        end
        if (din_valid && er[k]) begin
            cnt[k]++;
            pd[k] = din_data;
            pv[k] = 1;
            pc[k] = (cnt[k] == ML[k]);
            idle[k] = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            model_step(0);
            model_step(1);
            if (rst) begin
                q0.delete();
                q1.delete();
            end
        end
    end

    initial begin
        logic [16:0] exp;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                for (int k = 0; k < 2; k++) begin
                    chk("din_ready", k, 17'(dut_rdy[k]), 17'(er[k]));
                    chk("dout_valid", k, 17'(dut_vld[k]), 17'(ev[k]));
                    if (dut_vld[k] && dout_ready) begin
                        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_out dut%0d t=%0t got=%h want=none",
                                     k, $time, dut_dat[k]);
                        end else begin
                            exp = (k == 0) ? q0.pop_front() : q1.pop_front();
                            chk("dout_data", k, dut_dat[k], exp);
                        end
                    end
                end
            end
        end
    end

    task automatic cyc(input logic v, input logic [15:0] d, input logic r);
        din_valid  = v;
        din_data   = d;
        dout_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        repeat (n) cyc(1'b0, 16'h0, 1'b1);
    endtask

    initial begin
        int pvv;
        int prr;
        #1 rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk("rst_ready", k, 17'(dut_rdy[k]), 17'd1);
            chk("rst_valid", k, 17'(dut_vld[k]), 17'd0);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b1);
        idle_n(12);

        cyc(1'b1, 16'h000A, 1'b1);
        cyc(1'b1, 16'h000B, 1'b1);
        idle_n(12);

        cyc(1'b1, 16'h0031, 1'b1);
        cyc(1'b1, 16'h0032, 1'b1);
        repeat (20) cyc(1'b1, 16'h0033, 1'b0);
        cyc(1'b1, 16'h0033, 1'b1);
        cyc(1'b1, 16'h0034, 1'b1);
        idle_n(12);

        cyc(1'b1, 16'h0041, 1'b1);
        repeat (TO - 1) cyc(1'b0, 16'h0, 1'b1);
        cyc(1'b1, 16'h0042, 1'b1);
        cyc(1'b1, 16'h0043, 1'b1);
        idle_n(12);

        cyc(1'b1, 16'h0011, 1'b1);
        cyc(1'b1, 16'h0022, 1'b1);
        idle_n(12);

        cyc(1'b1, 16'h0061, 1'b1);
        cyc(1'b1, 16'h0062, 1'b1);
        cyc(1'b1, 16'h0063, 1'b1);
        #2 rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("async_rst_ready", k, 17'(dut_rdy[k]), 17'd1);
            chk("async_rst_valid", k, 17'(dut_vld[k]), 17'd0);
        end
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        rst = 1'b0;
        for (int i = 1; i <= 4; i++) cyc(1'b1, 16'(16'h70 + i), 1'b1);
        idle_n(12);

        repeat (30) begin
            pvv = $urandom_range(3) * 30 + 5;
            prr = $urandom_range(2) * 35 + 30;
            repeat (50) begin
                cyc(1'($urandom_range(99) < pvv), 16'($urandom),
                    1'($urandom_range(99) < prr));
            end
        end

        idle_n(20);
        chk("drain_q", 0, 17'(q0.size()), 17'd0);
        chk("drain_q", 1, 17'(q1.size()), 17'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
